// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU hierarchy:
// compare function codes, result codes, sequencer states.
package alu_pkg;

  localparam logic [1:0] FUN_NOP = 2'b00;
  localparam logic [1:0] FUN_EQ  = 2'b01;
  localparam logic [1:0] FUN_GT  = 2'b10;
  localparam logic [1:0] FUN_LT  = 2'b11;

  localparam int unsigned CODE_EQ = 1;
  localparam int unsigned CODE_GT = 2;
  localparam int unsigned CODE_LT = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EQ_ISSUE,
    S_EQ_WAIT,
    S_GT_ISSUE,
    S_GT_WAIT,
    S_RESP
  } cmp_state_e;

endpackage

// File: rtl/cmp_sequencer.sv
// Drives the compare unit through EQ then GT operations and
// folds the result codes into a one-hot eq/gt/lt response.
module cmp_sequencer
  import alu_pkg::*;
#(
  parameter int Operand_SIZE = 16,
  parameter int ALU_OUT      = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [Operand_SIZE-1:0] req_A,
  input  logic [Operand_SIZE-1:0] req_B,
  output logic [Operand_SIZE-1:0] A,
  output logic [Operand_SIZE-1:0] B,
  output logic [1:0]              ALU_FUN,
  output logic                    CMP_Enable,
  input  logic [ALU_OUT-1:0]      CMP_OUT,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_eq,
  output logic                    rsp_gt,
  output logic                    rsp_lt,
  output logic                    rsp_err
);

  localparam logic [ALU_OUT-1:0] C_ZERO = '0;
  localparam logic [ALU_OUT-1:0] C_EQ = ALU_OUT'(CODE_EQ);
  localparam logic [ALU_OUT-1:0] C_GT = ALU_OUT'(CODE_GT);

  cmp_state_e state_q, state_d;

  logic [Operand_SIZE-1:0] a_q, a_d;
  logic [Operand_SIZE-1:0] b_q, b_d;
  logic [1:0] fun_q, fun_d;
  logic en_q, en_d;
  logic vld_q, vld_d;
  logic eq_q, eq_d;
  logic gt_q, gt_d;
  logic lt_q, lt_d;
  logic err_q, err_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          a_d     = req_A;
          b_d     = req_B;
          state_d = S_EQ_ISSUE;
        end
      end
      S_EQ_ISSUE: state_d = S_EQ_WAIT;
      S_EQ_WAIT: begin
        unique case (1'b1)
          (CMP_OUT == C_EQ): begin
            eq_d    = 1'b1;
            state_d = S_RESP;
          end
          (CMP_OUT == C_ZERO): begin
            state_d = S_GT_ISSUE;
          end
          default: begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        endcase
      end
      S_GT_ISSUE: state_d = S_GT_WAIT;
      S_GT_WAIT: begin
        // zero after a failed EQ means strictly less
        unique case (1'b1)
          (CMP_OUT == C_GT):   gt_d  = 1'b1;
          (CMP_OUT == C_ZERO): lt_d  = 1'b1;
          default:             err_d = 1'b1;
        endcase
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // registered outputs follow the state being entered
    en_d  = (state_d == S_EQ_ISSUE) ||
            (state_d == S_GT_ISSUE);
    fun_d = FUN_NOP;
    if (state_d == S_EQ_ISSUE) fun_d = FUN_EQ;
    if (state_d == S_GT_ISSUE) fun_d = FUN_GT;
    vld_d = (state_d == S_RESP);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      fun_q   <= FUN_NOP;
      en_q    <= 1'b0;
      vld_q   <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fun_q   <= fun_d;
      en_q    <= en_d;
      vld_q   <= vld_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign A          = a_q;
  assign B          = b_q;
  assign ALU_FUN    = fun_q;
  assign CMP_Enable = en_q;
  assign rsp_valid  = vld_q;
  assign rsp_eq     = eq_q;
  assign rsp_gt     = gt_q;
  assign rsp_lt     = lt_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_cmp_sequencer.sv
// Bench for cmp_sequencer with a behavioural compare unit
// as responder and a scoreboard of expected responses.
module tb_cmp_sequencer;
  import alu_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_A = '0;
  logic [15:0] req_B = '0;
  logic [15:0] A, B;
  logic [1:0]  ALU_FUN;
  logic        CMP_Enable;
  logic [31:0] CMP_OUT;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_eq, rsp_gt, rsp_lt, rsp_err;

  logic [31:0] cu_out;
  logic        force_err = 1'b0;

  int n_run  = 0;
  int n_fail = 0;
  int edge_n = 0;

  typedef struct {
    logic [3:0] flags;
    int         lat;
    logic [7:0] fun;
    int         acc;
  } exp_t;

  exp_t sb[$];

  cmp_sequencer #(.Operand_SIZE(16), .ALU_OUT(32)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_A      (req_A),
    .req_B      (req_B),
    .A          (A),
    .B          (B),
    .ALU_FUN    (ALU_FUN),
    .CMP_Enable (CMP_Enable),
    .CMP_OUT    (CMP_OUT),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_eq     (rsp_eq),
    .rsp_gt     (rsp_gt),
    .rsp_lt     (rsp_lt),
    .rsp_err    (rsp_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) edge_n++;

  // compare unit: registered result, unsigned
  always @(posedge CLK or negedge RST) begin
    if (!RST) cu_out <= '0;
    else if (CMP_Enable) begin
      case (ALU_FUN)
        FUN_EQ:  cu_out <= (A == B) ? 32'd1 : 32'd0;
        FUN_GT:  cu_out <= (A > B)  ? 32'd2 : 32'd0;
        FUN_LT:  cu_out <= (A < B)  ? 32'd3 : 32'd0;
        default: cu_out <= '0;
      endcase
    end
  end

  assign CMP_OUT = force_err ? 32'd3 : cu_out;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  logic [7:0] fun_hist = '0;
  logic       prev_v   = 1'b0;

  always @(negedge CLK) begin
    if (!RST) begin
      fun_hist = '0;
      prev_v   = 1'b0;
    end else begin
      if (ALU_FUN != FUN_NOP)
        fun_hist = {fun_hist[5:0], ALU_FUN};
      if (CMP_Enable !== (ALU_FUN != FUN_NOP))
        chk("en_vs_fun", {31'd0, CMP_Enable},
            {31'd0, ALU_FUN != FUN_NOP});
      if (rsp_valid && !prev_v) begin
        if (sb.size() == 0) begin
          chk("spurious_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("flags",
              {28'd0, rsp_eq, rsp_gt, rsp_lt, rsp_err},
              {28'd0, e.flags});
          chk("latency", edge_n - e.acc + 1, e.lat);
          chk("fun_seq", {24'd0, fun_hist},
              {24'd0, e.fun});
        end
        fun_hist = '0;
      end
      prev_v = rsp_valid;
    end
  end

  // call at a negedge; returns at the negedge after acceptance
  task automatic send(input logic [15:0] a,
                      input logic [15:0] b,
                      input logic err,
                      output int acc);
    exp_t e;
    bit   done;
    done = 0;
    acc  = -1;
    if (err) begin
      e.flags = 4'b0001; e.lat = 3; e.fun = 8'h01;
    end else if (a == b) begin
      e.flags = 4'b1000; e.lat = 3; e.fun = 8'h01;
    end else if (a > b) begin
      e.flags = 4'b0100; e.lat = 5; e.fun = 8'h06;
    end else begin
      e.flags = 4'b0010; e.lat = 5; e.fun = 8'h06;
    end
    req_valid = 1'b1;
    req_A = a;
    req_B = b;
    for (int i = 0; i < 30 && !done; i++) begin
      if (req_ready) begin
        acc   = edge_n + 1;
        e.acc = acc;
        sb.push_back(e);
        done  = 1;
        @(posedge CLK);
      end
      @(negedge CLK);
    end
    req_valid = 1'b0;
    if (!done) chk("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    bit done;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (sb.size() == 0 && !rsp_valid) done = 1;
      else @(negedge CLK);
    end
    if (!done) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_A"}, {16'd0, A}, 32'd0);
    chk({tag, "_B"}, {16'd0, B}, 32'd0);
    chk({tag, "_fun"}, {30'd0, ALU_FUN}, 32'd0);
    chk({tag, "_en"}, {31'd0, CMP_Enable}, 32'd0);
    chk({tag, "_vld"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_flags"},
        {28'd0, rsp_eq, rsp_gt, rsp_lt, rsp_err}, 32'd0);
  endtask

  initial begin
    int acc1, acc2, h;
    bit seen;

    #2 RST = 1'b0;
    #1 chk_zero("reset");
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    chk("rdy_after_rst", {31'd0, req_ready}, 32'd1);
    @(negedge CLK);

    send(16'd5, 16'd5, 1'b0, acc1);
    wait_done();
    send(16'h8000, 16'h7FFF, 1'b0, acc1);
    wait_done();
    send(16'h0003, 16'hFFFF, 1'b0, acc1);
    wait_done();

    // throughput with rsp_ready tied high
    send(16'h0102, 16'h0102, 1'b0, acc1);
    send(16'h0202, 16'h0202, 1'b0, acc2);
    chk("thru_eq", acc2 - acc1, 32'd4);
    send(16'h0010, 16'h0001, 1'b0, acc2);
    wait_done();
    send(16'h0001, 16'h0010, 1'b0, acc1);
    send(16'h0001, 16'h0002, 1'b0, acc2);
    chk("thru_ne", acc2 - acc1, 32'd6);
    wait_done();

    // stalled response with a pending second request
    rsp_ready = 1'b0;
    send(16'd5, 16'd9, 1'b0, acc1);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (rsp_valid) seen = 1;
      else @(negedge CLK);
    end
    if (!seen) chk("stall_timeout", 32'd0, 32'd1);
    req_valid = 1'b1;
    req_A = 16'h1234;
    req_B = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("stall_rdy", {31'd0, req_ready}, 32'd0);
      chk("stall_vld", {31'd0, rsp_valid}, 32'd1);
      chk("stall_flags",
          {28'd0, rsp_eq, rsp_gt, rsp_lt, rsp_err},
          32'h2);
      chk("stall_A", {16'd0, A}, 32'd5);
    end
    rsp_ready = 1'b1;
    h = edge_n + 1;
    send(16'h1234, 16'h1234, 1'b0, acc2);
    chk("accept_after_hs", acc2, h + 1);
    wait_done();

    // reset during GT_WAIT
    send(16'h8000, 16'h0001, 1'b0, acc1);
    repeat (3) @(negedge CLK);
    chk("gtwait_en", {31'd0, CMP_Enable}, 32'd0);
    RST = 1'b0;
    #1 chk_zero("mid_rst");
    sb.delete();
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    chk("rdy_after_abort", {31'd0, req_ready}, 32'd1);
    repeat (6) @(negedge CLK);
    chk("no_rsp_after_abort", {31'd0, rsp_valid}, 32'd0);
    send(16'd7, 16'd2, 1'b0, acc1);
    wait_done();

    // illegal code in EQ_WAIT
    send(16'd4, 16'd4, 1'b1, acc1);
    force_err = 1'b1;
    repeat (2) @(negedge CLK);
    force_err = 1'b0;
    wait_done();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cmp_sequencer.md
# cmp_sequencer

Initiator-side sequencer for the compare unit of the 16-bit ALU hierarchy. It accepts operand pairs on a valid/ready request port. It then issues one or two single-function compare operations (EQ, then GT if needed) to the compare unit, and decodes the registered result codes into a one-hot three-way result (eq/gt/lt) on a valid/ready response port. It sits between the ALU control path and the compare unit, and owns the compare unit's `ALU_FUN`, `CMP_Enable`, `A` and `B` inputs.

## Interface
- `Operand_SIZE`, 16, operand width.
- `ALU_OUT`, 32, width of the compare unit's result bus.

- `CLK` in 1: single clock; all state updates on rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when high together with `req_valid`.
- `req_A`, `req_B` in `Operand_SIZE`: operands, unsigned.
- `A`, `B` out `Operand_SIZE`: operands driven to the compare unit.
- `ALU_FUN` out 2: compare function. 00 = NOP, 01 = EQ, 10 = GT, 11 = LT.
- `CMP_Enable` out 1: compare-unit enable.
- `CMP_OUT` in `ALU_OUT`: registered result from the compare unit.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed when high together with `rsp_valid`.
- `rsp_eq`, `rsp_gt`, `rsp_lt` out 1: one-hot result; all zero when `rsp_err` is set.
- `rsp_err` out 1: the compare unit returned an illegal code.

## Operation
- States: IDLE, EQ_ISSUE, EQ_WAIT, GT_ISSUE, GT_WAIT, RESP. State, and every output except `req_ready`, is a register.
- IDLE
  - `req_ready` = 1.
  - On `req_valid & req_ready`: latch `req_A`/`req_B` into the `A`/`B` registers, then go to EQ_ISSUE.
- EQ_ISSUE
  - `CMP_Enable` = 1, `ALU_FUN` = 01.
  - Next state: EQ_WAIT.
- EQ_WAIT (`CMP_Enable` = 0, `ALU_FUN` = 00). Sample `CMP_OUT`:
  - 1: `rsp_eq` = 1, go to RESP.
  - 0: go to GT_ISSUE.
  - Any other value: `rsp_err` = 1, go to RESP.
- GT_ISSUE
  - `CMP_Enable` = 1, `ALU_FUN` = 10.
  - Next state: GT_WAIT.
- GT_WAIT (`CMP_Enable` = 0). Sample `CMP_OUT`:
  - 2: `rsp_gt` = 1.
  - 0: `rsp_lt` = 1 (not equal and not greater).
  - Any other value: `rsp_err` = 1.
  - Next state: RESP.
- RESP
  - `rsp_valid` = 1; flags are held stable.
  - On `rsp_ready`: clear `rsp_valid` and all flags, go to IDLE.
- `req_ready` = 0 in every state except IDLE. Only one transaction is in flight; `req_valid` is ignored outside IDLE.
- The `A`/`B` outputs hold the latched operands until the next acceptance. `ALU_FUN` = 00 and `CMP_Enable` = 0 outside the ISSUE states.
- Comparison is unsigned, as implemented by the compare unit. The sequencer decodes only the low 2 bits' worth of code. Any non-zero bit of `CMP_OUT` outside the expected value counts as illegal.
- Reset values: state IDLE; `A`, `B`, `ALU_FUN`, `CMP_Enable`, `rsp_valid` and all `rsp_*` flags = 0; `req_ready` = 1 after reset is released.
- Reset mid-transaction aborts it. No response is produced, and the compare unit sees `CMP_Enable` = 0 immediately.

## Timing
- Request accepted at edge 0. EQ_ISSUE occupies cycle 1. The compare unit registers its result at edge 1, and the sequencer samples it in EQ_WAIT (cycle 2).
- Equal operands: `rsp_valid` rises in cycle 3, a latency of 3 cycles.
- Unequal operands: GT_ISSUE in cycle 3, GT_WAIT in cycle 4, `rsp_valid` in cycle 5, a latency of 5 cycles.
- Throughput with `rsp_ready` tied high:
  - One request per 4 cycles (equal).
  - One request per 6 cycles (unequal), counting the return to IDLE.
- `rsp_valid` and the flags are stable while `rsp_ready` is low; there is no bound on the stall.
- `req_ready` is combinational from state only, with no path from `req_valid`.

## Structure
- Shared package `alu_pkg` holds:
  - the `ALU_FUN` codes (`FUN_NOP`, `FUN_EQ`, `FUN_GT`, `FUN_LT`);
  - the expected result codes (`CODE_EQ` = 1, `CODE_GT` = 2, `CODE_LT` = 3);
  - the state enum for `cmp_sequencer`.
- No sub-module. The bench instantiates the existing compare unit as the responder, with `CMP_Enable`/`ALU_FUN`/`A`/`B` driven by this block.

## Test plan
- `A` = 5, `B` = 5, `rsp_ready` = 1:
  - `ALU_FUN` shows 01 only;
  - `rsp_valid` rises in cycle 3 with eq = 1, gt = 0, lt = 0, err = 0.
- `A` = 0x8000, `B` = 0x7FFF:
  - `ALU_FUN` sequence is 01 then 10;
  - `rsp_valid` rises in cycle 5 with gt = 1 (unsigned).
- `A` = 0x0003, `B` = 0xFFFF: `rsp_lt` = 1 in cycle 5, eq = gt = err = 0.
- `rsp_ready` held low for 4 cycles after `rsp_valid`, with a second `req_valid` asserted throughout:
  - flags stay stable and `req_ready` stays 0;
  - the second request is accepted the cycle after the response handshake completes.
- `RST` asserted low during GT_WAIT:
  - all outputs go to 0 immediately and no `rsp_valid` is produced;
  - after release, a request with `A` = 7, `B` = 2 completes with gt = 1.
- Bench forces `CMP_OUT` = 3 in EQ_WAIT: `rsp_err` = 1 in cycle 3 and eq = gt = lt = 0.
